// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit that owns HI/LO and reports Busy to the hazard logic.
// Define MD_MADD_EN to enable madd/maddu on MDOp 110/111; otherwise those codes are no-ops.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Busy
);
   typedef enum logic [2:0] {
      OP_MULT = 3'b000, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU
   } md_op_e;

   localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES);

   md_op_e      op;
   logic [4:0]  cnt, cnt_ld;
   logic [31:0] hi_q, lo_q, phi, plo;
   logic [31:0] quo_s, rem_s;
   logic [63:0] prod_s, prod_u, res;
   logic        load;

   assign op   = md_op_e'(MDOp);
   assign Busy = (cnt != 5'd0);
   assign HI   = hi_q;
   assign LO   = lo_q;

   // Low 64 bits of the sign-extended product equal the signed 32x32 product.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};
   assign quo_s  = $signed(A) / $signed(B);
   assign rem_s  = $signed(A) % $signed(B);

   // Result is formed at the Start edge and parked in PHI/PLO until the counter expires.
   always_comb begin
      load   = 1'b0;
      cnt_ld = 5'd0;
      res    = {hi_q, lo_q};
      if (Start && !Busy) begin
         case (op)
            OP_MULT: begin
               load = 1'b1; cnt_ld = MULT_LD; res = prod_s;
            end
            OP_MULTU: begin
               load = 1'b1; cnt_ld = MULT_LD; res = prod_u;
            end
            OP_DIV: begin
               load = 1'b1; cnt_ld = DIV_LD;
               if (B == 32'd0)
                  res = {hi_q, lo_q};
               else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)
                  res = {32'd0, 32'h8000_0000};
               else
                  res = {rem_s, quo_s};
            end
            OP_DIVU: begin
               load = 1'b1; cnt_ld = DIV_LD;
               if (B != 32'd0) res = {A % B, A / B};
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
               load = 1'b1; cnt_ld = MULT_LD; res = {hi_q, lo_q} + prod_s;
            end
            OP_MADDU: begin
               load = 1'b1; cnt_ld = MULT_LD; res = {hi_q, lo_q} + prod_u;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= 5'd0;
         hi_q <= 32'd0;
         lo_q <= 32'd0;
         phi  <= 32'd0;
         plo  <= 32'd0;
      end else if (Busy) begin
         cnt <= cnt - 5'd1;
         if (cnt == 5'd1) begin
            hi_q <= phi;
            lo_q <= plo;
         end
      end else if (Start) begin
         if (load) begin
            phi <= res[63:32];
            plo <= res[31:0];
            cnt <= cnt_ld;
         end
         if (op == OP_MTHI) hi_q <= A;
         if (op == OP_MTLO) lo_q <= A;
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed plus random stimulus for md_unit, checked against an arithmetic reference model.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [2:0]  MDOp = 3'd0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic [31:0] HI, LO;
   logic        Busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
      .A(A), .B(B), .HI(HI), .LO(LO), .Busy(Busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: architectural result of one accepted op, from the current expected HI/LO.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] nh, output logic [31:0] nl, output int n);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, acc;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      nh = exp_hi;
      nl = exp_lo;
      n  = 0;
      case (op)
         3'd0: begin acc = 64'(sa * sb); {nh, nl} = acc; n = MC; end
         3'd1: begin acc = ua * ub;      {nh, nl} = acc; n = MC; end
         3'd2: begin
            n = DC;
            if (b != 32'd0) begin
               q  = sa / sb;
               r  = sa - q * sb;
               nl = q[31:0];
               nh = r[31:0];
            end
         end
         3'd3: begin
            n = DC;
            if (b != 32'd0) begin
               acc = ua / ub; nl = acc[31:0];
               acc = ua % ub; nh = acc[31:0];
            end
         end
         3'd4: nh = a;
         3'd5: nl = a;
`ifdef MD_MADD_EN
         3'd6: begin acc = {exp_hi, exp_lo} + 64'(sa * sb); {nh, nl} = acc; n = MC; end
         3'd7: begin acc = {exp_hi, exp_lo} + ua * ub;      {nh, nl} = acc; n = MC; end
`endif
         default: ;
      endcase
   endtask

   // Issue one op from an idle cycle, check Busy/hold for its latency, then the result.
   // poke drives a stray mtlo during the busy window, which must be ignored.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
      logic [31:0] nh, nl;
      int n;
      model(op, a, b, nh, nl, n);
      Start = 1'b1; MDOp = op; A = a; B = b;
      @(posedge clk); #1 Start = 1'b0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk); Start = 1'b0;
         check("busy_on", 32'(Busy), 32'd1);
         check("hi_hold", HI, exp_hi);
         check("lo_hold", LO, exp_lo);
         if (poke && k == 2) begin
            Start = 1'b1; MDOp = 3'b101; A = $urandom;
         end
      end
      exp_hi = nh;
      exp_lo = nl;
      @(negedge clk);
      check("busy_off", 32'(Busy), 32'd0);
      check("hi_res", HI, exp_hi);
      check("lo_res", LO, exp_lo);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(Busy), 32'd0);

      run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("mult_hi_k", HI, 32'hFFFF_FFFF);
      check("mult_lo_k", LO, 32'hFFFF_FFFE);
      run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      check("multu_hi_k", HI, 32'h0000_0001);
      check("multu_lo_k", LO, 32'hFFFF_FFFE);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_lo_k", LO, 32'hFFFF_FFFD);
      check("div_hi_k", HI, 32'hFFFF_FFFF);
      run_op(3'd3, 32'd7, 32'd2, 1'b0);
      check("divu_lo_k", LO, 32'd3);
      check("divu_hi_k", HI, 32'd1);

      run_op(3'd4, 32'h11, 32'd0, 1'b0);
      run_op(3'd5, 32'h22, 32'd0, 1'b0);
      run_op(3'd2, 32'd5, 32'd0, 1'b0);
      check("div0_hi_k", HI, 32'h11);
      check("div0_lo_k", LO, 32'h22);
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("divovf_lo_k", LO, 32'h8000_0000);
      check("divovf_hi_k", HI, 32'd0);

      run_op(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
      check("mthi_k", HI, 32'hDEAD_BEEF);
      run_op(3'd0, 32'd3, 32'd7, 1'b1);
      check("poke_lo_k", LO, 32'd21);

      run_op(3'd4, 32'd0, 32'd0, 1'b0);
      run_op(3'd5, 32'd5, 32'd0, 1'b0);
      run_op(3'd6, 32'd3, 32'd4, 1'b0);
      check("madd_hi_k", HI, 32'd0);
`ifdef MD_MADD_EN
      check("madd_lo_k", LO, 32'h11);
`else
      check("madd_lo_k", LO, 32'd5);
`endif

      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, (rop <= 3'd1) && ($urandom_range(0, 1) == 1));
      end

      run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
      Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
      @(posedge clk); #1 Start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(Busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("rst_mid_busy", 32'(Busy), 32'd0);
      check("rst_mid_hi", HI, exp_hi);
      check("rst_mid_lo", LO, exp_lo);
      repeat (DC + 2) @(negedge clk);
      check("rst_late_hi", HI, exp_hi);
      check("rst_late_lo", LO, exp_lo);
      check("rst_late_busy", 32'(Busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/md_unit.md
# md_unit

- Execute-stage multiply/divide unit of the pipelined MIPS CPU.
- Owns the HI/LO register pair, runs mult/multu/div/divu with fixed multi-cycle latency, and handles mthi/mtlo.
- Drives Busy_E to the hazard/stall logic. That logic stalls any md-class instruction in D while Busy is high or Start is high in E.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (and madd/maddu); legal range 1..31
- DIV_CYCLES, 10, Busy cycles for div/divu; legal range 1..31

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Start  in  1  qualifies MDOp for one cycle (E-stage md instruction valid)
- MDOp  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu
- A  in  32  rs operand (forwarded value from E)
- B  in  32  rt operand (forwarded value from E)
- HI  out  32  architectural HI (mfhi source)
- LO  out  32  architectural LO (mflo source)
- Busy  out  1  operation in flight; connects to hazard input Busy_E

## Operation
- State: HI, LO, pending result PHI/PLO, 5-bit down-counter cnt; Busy = (cnt != 0).
- Idle (cnt==0) with Start=1 on an edge:
  - mult/multu/div/divu/madd/maddu: result computed from A, B at that edge into PHI/PLO; cnt loaded with MULT_CYCLES or DIV_CYCLES.
  - mthi: HI<=A at that edge. mtlo: LO<=A at that edge. cnt stays 0, Busy never asserts.
- Running (cnt!=0): cnt decrements each edge. At the edge where cnt==1: HI<=PHI, LO<=PLO, cnt<=0.
- Start while Busy: ignored completely (no load, no mthi/mtlo). The hazard unit guarantees this never happens; verification flags it.
- Arithmetic:
  - mult: signed 32x32->64, HI = [63:32], LO = [31:0]. multu: unsigned.
  - div: LO = quotient truncated toward zero, HI = remainder with sign of dividend. divu: unsigned.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0): PHI/PLO captured as current HI/LO, so HI/LO end unchanged; Busy still runs DIV_CYCLES.
  - madd/maddu: {HI,LO} + signed/unsigned A*B, mod 2^64, using the HI/LO values at the Start edge.
- Reset: cnt, HI, LO, PHI, PLO all cleared to 0. An in-flight operation is discarded with no HI/LO write.

## Timing
- Reset values: HI=0, LO=0, Busy=0.
- Start sampled at edge t0. Busy is high during cycles t0+1 .. t0+N.
- HI/LO hold old values while Busy. New values are visible in the first cycle with Busy=0, t0+N+1.
- mthi/mtlo are visible the cycle after the Start edge.
- Back-to-back operations: the earliest accepted Start is in the first cycle Busy=0, giving zero bubble beyond the stall.
- HI/LO outputs are registered, with no combinational path from A/B/Start.
- Busy depends only on registered state.

## Configuration
- MD_MADD_EN defined: MDOp 110/111 perform madd/maddu as specified, with MULT_CYCLES latency.
- MD_MADD_EN undefined: MDOp 110/111 are no-ops. No state change, Busy stays 0, and no accumulate datapath is synthesized.

## Test plan
- Reset then idle: HI=0, LO=0, Busy=0. Assert reset at cycle 3 of a div: Busy=0 next cycle, HI=LO=0.
- mult A=0xFFFFFFFF, B=2: Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu with the same operands: HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2: Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2: LO=3, HI=1.
- With HI=0x11, LO=0x22, div A=5, B=0: after 10 cycles HI=0x11, LO=0x22. div 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi A=0xDEADBEEF: HI updated next cycle, Busy never high. Start mtlo asserted during a mult Busy window: ignored, and LO equals the mult result afterwards.
- MD_MADD_EN defined: set HI=0, LO=5 via mtlo, madd A=3, B=4: after 5 cycles HI=0, LO=0x11. MD_MADD_EN undefined: HI=0, LO=5 unchanged and Busy stays 0.
